// File: rtl/trace_capture_if.sv
// Fetch-side and trace-read signals of trace_capture, bundled for the processor
// (master) and the trace unit (slave).
interface trace_capture_if #(
  parameter int IR_W  = 16,
  parameter int PC_W  = 7,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             Arm;
  logic             Fetch;
  logic [PC_W-1:0]  PC_In;
  logic [IR_W-1:0]  IR_In;
  logic             Rd_Ready;
  logic             Rd_Valid;
  logic [PC_W-1:0]  Rd_PC;
  logic [IR_W-1:0]  Rd_IR;
  logic [CNT_W-1:0] Count;
  logic [CYC_W-1:0] Cycles;
  logic             Busy;
  logic             Halted;
  logic             Overflow;

  modport master (
    output Arm, Fetch, PC_In, IR_In, Rd_Ready,
    input  Rd_Valid, Rd_PC, Rd_IR, Count, Cycles, Busy, Halted, Overflow
  );

  modport slave (
    input  Arm, Fetch, PC_In, IR_In, Rd_Ready,
    output Rd_Valid, Rd_PC, Rd_IR, Count, Cycles, Busy, Halted, Overflow
  );
endinterface

// File: rtl/trace_capture.sv
// Run-control and instruction-trace unit: circular (PC, IR) capture buffer,
// hardware halt detection, saturating cycle counter and valid/ready trace read port.
module trace_capture #(
  parameter int              IR_W    = 16,
  parameter int              PC_W    = 7,
  parameter int              DEPTH   = 16,
  parameter logic [IR_W-1:0] HALT_IR = IR_W'(16'h5000),
  parameter bit              WRAP    = 1'b0,
  parameter int              CYC_W   = 32
) (
  input logic            Clk,
  input logic            Reset,
  trace_capture_if.slave tif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + IR_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, STOPPED} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic            halted_q, halted_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            full;
  logic            pop;
  logic            wr_en;
  logic            overwrite;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    cycles_d  = cycles_q;
    halted_d  = halted_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    overwrite = 1'b0;
    full      = (count_q == CW'(DEPTH));
    pop       = tif.Rd_Ready && (count_q != '0);

    if (tif.Arm) begin
      state_d  = CAPTURE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      cycles_d = '0;
      halted_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (state_q == CAPTURE && cycles_q != '1) cycles_d = cycles_q + 1'b1;

      if (state_q == CAPTURE && tif.Fetch) begin
        // A same-cycle pop frees a slot, so a full buffer can still accept the push.
        if (!full || pop) begin
          wr_en = 1'b1;
        end else if (WRAP) begin
          wr_en     = 1'b1;
          overwrite = 1'b1;
          ovf_d     = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        if (tif.IR_In == HALT_IR) begin
          halted_d = 1'b1;
          state_d  = STOPPED;
        end
      end

      if (pop || overwrite) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_en && !pop && !full) count_d = count_q + 1'b1;
      else if (pop && !wr_en)     count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is cleared by reset so the read port shows zeros before the first capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {tif.PC_In, tif.IR_In};
    end
  end

  assign tif.Rd_Valid = (count_q != '0);
  assign tif.Rd_PC    = mem_q[rd_ptr_q][EW-1:IR_W];
  assign tif.Rd_IR    = mem_q[rd_ptr_q][IR_W-1:0];
  assign tif.Count    = count_q;
  assign tif.Cycles   = cycles_q;
  assign tif.Busy     = (state_q == CAPTURE);
  assign tif.Halted   = halted_q;
  assign tif.Overflow = ovf_q;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: three configurations driven in lockstep, each shadowed
// by a queue-based reference model; a negedge monitor compares every output.
module tb_trace_capture;

  localparam logic [15:0] HALT = 16'h5000;

  typedef struct packed {
    logic        vld;
    logic        busy;
    logic        halt;
    logic        ovf;
    logic [7:0]  cnt;
    logic [31:0] cyc;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic        dchk;
  } snap_t;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b0;
  logic        arm   = 1'b0;
  logic        fetch = 1'b0;
  logic        rdy   = 1'b0;
  logic [6:0]  pc    = '0;
  logic [15:0] ir    = '0;

  int checks   = 0;
  int failures = 0;

  snap_t obs_a [3];
  snap_t exp_a [3];

  always #5 Clk = ~Clk;

  // g[0]: DEPTH 16, WRAP 0, CYC_W 32; g[1]: DEPTH 4, WRAP 0, CYC_W 4; g[2]: DEPTH 4, WRAP 1, CYC_W 8
  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int DEP = (gi == 0) ? 16 : 4;
    localparam bit WR  = (gi == 2);
    localparam int CW  = (gi == 0) ? 32 : ((gi == 1) ? 4 : 8);

    trace_capture_if #(.IR_W(16), .PC_W(7), .DEPTH(DEP), .CYC_W(CW)) ifc ();

    trace_capture #(
      .IR_W(16), .PC_W(7), .DEPTH(DEP), .HALT_IR(HALT), .WRAP(WR), .CYC_W(CW)
    ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .tif  (ifc.slave)
    );

    assign ifc.Arm      = arm;
    assign ifc.Fetch    = fetch;
    assign ifc.PC_In    = pc;
    assign ifc.IR_In    = ir;
    assign ifc.Rd_Ready = rdy;

    assign obs_a[gi] = '{vld: ifc.Rd_Valid, busy: ifc.Busy, halt: ifc.Halted,
                         ovf: ifc.Overflow, cnt: 8'(ifc.Count), cyc: 32'(ifc.Cycles),
                         pc: ifc.Rd_PC, ir: ifc.Rd_IR, dchk: 1'b0};

    // Reference model: trace is a plain FIFO queue; state is 0 idle, 1 capture, 2 stopped.
    logic [22:0]     q [$];
    int              st       = 0;
    bit              hlt      = 1'b0;
    bit              ovf      = 1'b0;
    bit              zero_mem = 1'b1;
    longint unsigned cyc      = 0;
    snap_t           es       = '0;

    always @(posedge Clk or posedge Reset) begin
      bit          popd;
      logic [22:0] head;
      if (Reset) begin
        q.delete(); st = 0; hlt = 1'b0; ovf = 1'b0; cyc = 0; zero_mem = 1'b1;
      end else if (arm) begin
        q.delete(); st = 1; hlt = 1'b0; ovf = 1'b0; cyc = 0;
      end else begin
        popd = rdy && (q.size() > 0);
        if (st == 1 && cyc < ((64'd1 << CW) - 1)) cyc++;
        if (popd) void'(q.pop_front());
        if (st == 1 && fetch) begin
          if (q.size() < DEP) begin
            q.push_back({pc, ir});
            zero_mem = 1'b0;
          end else begin
            ovf = 1'b1;
            if (WR) begin
              void'(q.pop_front());
              q.push_back({pc, ir});
              zero_mem = 1'b0;
            end
          end
          if (ir == HALT) begin
            hlt = 1'b1;
            st  = 2;
          end
        end
      end
      head    = (q.size() > 0) ? q[0] : 23'd0;
      es.vld  = (q.size() > 0);
      es.busy = (st == 1);
      es.halt = hlt;
      es.ovf  = ovf;
      es.cnt  = 8'(q.size());
      es.cyc  = 32'(cyc);
      es.pc   = head[22:16];
      es.ir   = head[15:0];
      es.dchk = (q.size() > 0) || zero_mem;
    end

    assign exp_a[gi] = es;
  end

  task automatic cmp(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cfg%0d t=%0t got=%0h expected=%0h", nm, k, $time, a, e);
    end
  endtask

  always @(negedge Clk) begin
    for (int k = 0; k < 3; k++) begin
      cmp("Rd_Valid", k, 32'(obs_a[k].vld),  32'(exp_a[k].vld));
      cmp("Busy",     k, 32'(obs_a[k].busy), 32'(exp_a[k].busy));
      cmp("Halted",   k, 32'(obs_a[k].halt), 32'(exp_a[k].halt));
      cmp("Overflow", k, 32'(obs_a[k].ovf),  32'(exp_a[k].ovf));
      cmp("Count",    k, 32'(obs_a[k].cnt),  32'(exp_a[k].cnt));
      cmp("Cycles",   k, obs_a[k].cyc,       exp_a[k].cyc);
      if (exp_a[k].dchk) begin
        cmp("Rd_PC", k, 32'(obs_a[k].pc), 32'(exp_a[k].pc));
        cmp("Rd_IR", k, 32'(obs_a[k].ir), 32'(exp_a[k].ir));
      end
    end
  end

  task automatic step(input logic a, input logic f, input logic [6:0] p,
                      input logic [15:0] i, input logic r);
    @(posedge Clk);
    #1;
    arm = a; fetch = f; pc = p; ir = i; rdy = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 7'h00, 16'h0000, 1'b0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 1'b0, 7'h00, 16'h0000, 1'b1);
  endtask

  initial begin
    logic        ra, rf, rr;
    logic [15:0] rir;
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    step(1'b0, 1'b1, 7'h10, 16'h1234, 1'b0);
    drain(1);

    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 7'(i), 16'h1000 + 16'(i), 1'b0);
    idle(3);

    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(i), 16'h1000 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 7'h04, HALT, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 7'h7F, 16'h2222, 1'b0);
    idle(2);
    drain(7);

    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 7'(i), 16'h1000 + 16'(i), 1'b0);
    idle(2);
    drain(6);

    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(i), 16'h1000 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 7'h04, 16'h1004, 1'b1);
    idle(2);
    drain(5);

    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'(i + 8), 16'h3000 + 16'(i), 1'b0);
    idle(1);
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    step(1'b1, 1'b1, 7'h03, 16'h4444, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 7'h05, 16'h4445, 1'b0);
    idle(2);

    step(1'b1, 1'b0, 7'h00, 16'h0000, 1'b0);
    repeat (2500) begin
      ra  = ($urandom_range(0, 79) == 0);
      rf  = $urandom_range(0, 1) == 1;
      rr  = ($urandom_range(0, 2) == 0);
      rir = ($urandom_range(0, 149) == 0) ? HALT : 16'($urandom);
      step(ra, rf, 7'($urandom), rir, rr);
    end
    drain(20);
    idle(1);
    @(posedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Parametrised run-control and instruction-trace unit attached beside the programmable processor. It captures a (PC, IR) pair on every instruction fetch into a circular buffer and detects the halt instruction in hardware. It also counts execution cycles and exposes the buffered trace through a valid/ready read port. It replaces ad-hoc bench-side monitoring and halt waiting with a synthesizable block usable on the board and in simulation.

## Interface
- IR_W, default 16: instruction register width.
- PC_W, default 7: program counter width.
- DEPTH, default 16: trace entries; power of two, ≥ 2.
- HALT_IR, default 16'h5000: IR value recognised as halt (IR_W bits).
- WRAP, default 0: 0 = stop capturing when full; 1 = overwrite oldest entry.
- CYC_W, default 32: cycle counter width.

Ports:
- Clk  in  1  system clock, all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Arm  in  1  one-cycle pulse: clear buffer and counters, start capture.
- Fetch  in  1  one-cycle strobe: PC_In/IR_In hold a newly fetched instruction.
- PC_In  in  PC_W  program counter of the fetched instruction.
- IR_In  in  IR_W  fetched instruction.
- Rd_Ready  in  1  consumer accepts the head entry this cycle.
- Rd_Valid  out  1  buffer non-empty.
- Rd_PC  out  PC_W  PC of the oldest entry.
- Rd_IR  out  IR_W  IR of the oldest entry.
- Count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- Cycles  out  CYC_W  clocks spent in CAPTURE since the last Arm; saturating.
- Busy  out  1  state is CAPTURE.
- Halted  out  1  halt instruction captured since the last Arm.
- Overflow  out  1  at least one fetch was lost (WRAP=0) or overwritten (WRAP=1) since the last Arm.

## Operation
- States: IDLE, CAPTURE, STOPPED.
- IDLE → CAPTURE on Arm. Arm in any state clears the buffer, Count, Cycles, Halted and Overflow, then enters CAPTURE.
- CAPTURE, Fetch: write {PC_In, IR_In} at the write pointer. If IR_In == HALT_IR, write the entry, set Halted and go to STOPPED.
- CAPTURE, Fetch, buffer full, WRAP=0: entry is dropped, Overflow is set, and the state stays CAPTURE. A halt arriving while full still sets Halted and moves to STOPPED; the entry itself is dropped.
- CAPTURE, Fetch, buffer full, WRAP=1: oldest entry is overwritten, the read pointer advances, Count stays DEPTH, and Overflow is set.
- Fetch in IDLE or STOPPED is ignored.
- Read: Rd_Valid & Rd_Ready pops the head. Reads are allowed in every state. Rd_Ready while empty has no effect.
- Simultaneous push and pop: Count is unchanged. When full with WRAP=0, the pop frees the slot, so the push is accepted and Overflow is not set.
- Cycles increments once per clock in CAPTURE, including the cycle the halt is captured. It holds in other states and saturates at all ones.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: state IDLE; Count 0; Cycles 0; Rd_Valid 0; Busy, Halted and Overflow 0. Rd_PC/Rd_IR are 0, because storage resets to 0.
- Arm sampled at edge N: Busy=1 and cleared flags/counters are visible after edge N.
- Fetch sampled at edge N: Count and Rd_Valid update after edge N. Rd_PC/Rd_IR are combinational from the head, so they are valid in the same cycle as Rd_Valid.
- A halt fetch at edge N makes Halted=1 and Busy=0 after edge N. Cycles includes edge N.
- A pop at edge N presents the next head after edge N.
- Reset asserted mid-capture returns all outputs to reset values immediately, without waiting for a clock.
- Arm and Fetch in the same cycle: Arm wins, the fetch is discarded, and the buffer is empty afterwards.

## Test plan
- Reset, Arm, then 5 fetches with PC 00..04 and IR 1000..1004, and Rd_Ready=0 → Count=5, Rd_PC=00, Rd_IR=1000, Busy=1, Cycles equals the clocks elapsed since Arm.
- Fetches PC 00..03, then PC 04 with IR 5000 → Halted=1, Busy=0, Count=5. A later fetch leaves Count=5 and Cycles frozen. Draining with Rd_Ready=1 yields 5 entries in order, then Rd_Valid=0.
- WRAP=0, DEPTH=4, 6 fetches with PC 00..05 → Count=4, Overflow=1, head PC=00, last entry PC=03.
- WRAP=1, DEPTH=4, 6 fetches with PC 00..05 → Count=4, Overflow=1, drain returns PC 02,03,04,05.
- Full with WRAP=0, Fetch and Rd_Ready in the same cycle → Count stays 4, Overflow=0, head advances by one, the new entry is at the tail.
- Reset pulsed asynchronously between clock edges mid-capture → all outputs 0 before the next edge. Arm and Fetch in the same cycle → Count=0 afterwards.
